upc_serial_tx: RTL and testbench
================================

// Module: upc_serial_tx
// PURPOSE
//  Transmit side of the serial item-record link. Latches a 3-bit UPC code and a 1-bit
//  "marked" flag, then sends them as one framed, even-parity bit stream on a single
//  wire. The checkout-checker logic receives the stream at the far end of that wire.
//  The block sits between the switch/key front end and the link pin on the DE1-SoC top level.
// PARAMETERS
//  BIT_CYCLES  4  clocks each frame bit is held on tx; must be >= 1
//  CNT_W       8  width of the frames_sent counter
// PORTS
//  clk          in   1      system clock; all logic is on the rising edge
//  reset        in   1      synchronous, active-high reset
//  start        in   1      request to send; level-sampled, accepted only in IDLE
//  upc          in   3      UPC code to send, latched on acceptance
//  mark         in   1      marked flag to send, latched on acceptance
//  tx           out  1      serial line; idles high
//  busy         out  1      high while a frame is in progress
//  done         out  1      one-cycle pulse when a frame completes
//  frames_sent  out  CNT_W  count of completed frames, wraps around
// BEHAVIOUR
//  - Clock and reset: one clock, clk. Reset is synchronous and active-high.
//  - Reset: on any edge with reset=1 the outputs take these values:
//    tx=1, busy=0, done=0, frames_sent=0, FSM=IDLE, bit counter=0.
//    This also applies mid-frame; the partial frame is abandoned and is not counted.
//  - Frame: 7 bits, each bit held for exactly BIT_CYCLES clocks, sent in this order:
//    START(0), upc[2], upc[1], upc[0], mark, PAR, STOP(1).
//    PAR is the even-parity bit: PAR = ^{upc,mark}, computed from the latched values.
//  - FSM states: IDLE -> START -> DATA (4 bits, index 0..3) -> PARITY -> STOP -> IDLE.
//    A cycle counter runs 0..BIT_CYCLES-1. The FSM advances when the counter reaches
//    BIT_CYCLES-1; the counter then clears.
//  - Acceptance: at an edge where FSM=IDLE and start=1, upc and mark are captured into
//    shadow registers and the FSM enters START.
//  - Output timing: tx, busy and done are registered. After the accepting edge tx=0 and
//    busy=1. A frame occupies exactly 7*BIT_CYCLES cycles with busy=1.
//  - start while busy: ignored, and not queued.
//  - upc/mark changes while busy: no effect on the frame in flight.
//  - Frame completion: at the edge that ends the STOP bit the block returns to IDLE and,
//    for that single cycle, done=1. On the same edge frames_sent increments by 1,
//    wrapping modulo 2^CNT_W. In that cycle busy=0 and tx=1.
//  - Back-to-back frames: if start=1 in the done cycle (FSM=IDLE), it is accepted at the
//    next edge. The minimum gap between frames is therefore 1 idle cycle of tx=1.
//  - start held high continuously: frames repeat every 7*BIT_CYCLES+1 cycles.
//  - Reset and start both high on the same edge: reset wins and nothing is accepted.
//  - tx is glitch-free. It changes only on the rising edge of clk, driven directly
//    from a flop.
// TESTING (BIT_CYCLES=4 unless stated)
//  1. Reset: hold reset for 2 cycles -> tx=1, busy=0, done=0, frames_sent=0.
//     Hold start=0 for 10 cycles -> outputs unchanged.
//  2. Basic frame: upc=3'b101, mark=1, pulse start for 1 cycle -> tx sequence
//     0,1,0,1,1,1,1 with each bit 4 cycles wide. busy=1 for 28 cycles, then done=1 for
//     1 cycle, then frames_sent=1.
//  3. Zero frame: upc=3'b000, mark=0 -> tx sequence 0,0,0,0,0,0,1 (PAR=0).
//     Then upc=3'b110, mark=0 -> PAR=0. Then upc=3'b100, mark=0 -> PAR=1.
//  4. Isolation: start a frame with upc=3'b011, mark=0, then at cycle 6 change upc to
//     3'b100 and pulse start -> the frame still carries 0,1,1,0. No second frame is sent.
//  5. Reset mid-frame: assert reset at cycle 13 of a frame -> the next cycle has tx=1,
//     busy=0 and frames_sent unchanged. A following start sends a full, correct frame.
//  6. Streaming and wrap: CNT_W=2, start held high for 5 frames -> frames start 29 cycles
//     apart, with exactly 1 idle cycle between frames.
//     frames_sent steps 1,2,3,0,1. Also run with BIT_CYCLES=1: 7-cycle frames.

Source files
------------

// File: rtl/upc_serial_tx.sv
// Serial transmitter for item records: a START bit, upc[2:0], mark, even parity, then a STOP bit.
// Every frame bit is held on tx for BIT_CYCLES clocks, and tx idles high between frames.
module upc_serial_tx #(
    parameter int BIT_CYCLES = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       upc,
    input  logic             mark,
    output logic             tx,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] frames_sent
);

    localparam int             CW   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0]  LAST = CW'(BIT_CYCLES - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [3:0]    shift_q;
    logic          par_q;
    logic          bit_end;

    assign bit_end = (cnt == LAST);

    // NOTE: shift_q and par_q have no reset. They are loaded on every
    // acceptance and are never observed while the FSM is in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            tx          <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            frames_sent <= '0;
        end else begin
            // NOTE: non-blocking assignments only. A later assignment in this
            // block overrides an earlier one, so done defaults low here and is
            // raised only on the edge that ends a frame.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_q <= {upc, mark};
                        par_q   <= ^{upc, mark};
                        state   <= START;
                        cnt     <= '0;
                        idx     <= '0;
                        tx      <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                START, DATA, PARITY, STOP: begin
                    if (!bit_end) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        case (state)
                            START: begin
                                state   <= DATA;
                                tx      <= shift_q[3];
                                shift_q <= {shift_q[2:0], 1'b0};
                            end
                            DATA: begin
                                if (idx == 2'd3) begin
                                    state <= PARITY;
                                    tx    <= par_q;
                                end else begin
                                    idx     <= idx + 2'd1;
                                    tx      <= shift_q[3];
                                    shift_q <= {shift_q[2:0], 1'b0};
                                end
                            end
                            PARITY: begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
                            default: begin
                                state       <= IDLE;
                                tx          <= 1'b1;
                                busy        <= 1'b0;
                                done        <= 1'b1;
                                frames_sent <= frames_sent + 1'b1;
                            end
                        endcase
                    end
                end
                default: begin
                    // Recover from an unused encoding without emitting a frame.
                    state <= IDLE;
                    cnt   <= '0;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_upc_serial_tx.sv
// Directed bench for upc_serial_tx. dut_a is the default build. dut_b (CNT_W=2) and
// dut_c (BIT_CYCLES=1, CNT_W=2) run the streaming and counter-wrap cases.
module tb_upc_serial_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start_a = 1'b0;
    logic       start_s = 1'b0;
    logic [2:0] upc = 3'b000;
    logic       mark = 1'b0;

    logic       tx_a, busy_a, done_a;
    logic [7:0] fs_a;
    logic       tx_b, busy_b, done_b;
    logic [1:0] fs_b;
    logic       tx_c, busy_c, done_c;
    logic [1:0] fs_c;

    int n_vec  = 0;
    int n_miss = 0;
    int exp_fs = 0;

    always #5 clk = ~clk;

    upc_serial_tx #(.BIT_CYCLES(4), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .upc(upc), .mark(mark),
        .tx(tx_a), .busy(busy_a), .done(done_a), .frames_sent(fs_a));

    upc_serial_tx #(.BIT_CYCLES(4), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .start(start_s), .upc(upc), .mark(mark),
        .tx(tx_b), .busy(busy_b), .done(done_b), .frames_sent(fs_b));

    upc_serial_tx #(.BIT_CYCLES(1), .CNT_W(2)) dut_c (
        .clk(clk), .reset(reset), .start(start_s), .upc(upc), .mark(mark),
        .tx(tx_c), .busy(busy_c), .done(done_c), .frames_sent(fs_c));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_tx"},   {31'd0, tx_a},   32'd1);
        check({tag, "_busy"}, {31'd0, busy_a}, 32'd0);
        check({tag, "_done"}, {31'd0, done_a}, 32'd0);
        check({tag, "_fs"},   {24'd0, fs_a},   exp_fs);
    endtask

    // Sends one frame on dut_a and checks every bit-time. When disturb >= 0, upc is
    // changed and start is pulsed at that cycle of the frame.
    task automatic run_frame(input logic [2:0] u, input logic m, input logic [6:0] bits,
                             input int disturb);
        upc = u; mark = m; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int k = 0; k < 28; k++) begin
            check("frame_tx",   {31'd0, tx_a},   {31'd0, bits[6 - k/4]});
            check("frame_busy", {31'd0, busy_a}, 32'd1);
            check("frame_done", {31'd0, done_a}, 32'd0);
            if (k == disturb) upc = 3'b100;
            start_a = (k == disturb);
            tick();
        end
        start_a = 1'b0;
        exp_fs = (exp_fs + 1) % 256;
        check("end_done", {31'd0, done_a}, 32'd1);
        check("end_busy", {31'd0, busy_a}, 32'd0);
        check("end_tx",   {31'd0, tx_a},   32'd1);
        check("end_fs",   {24'd0, fs_a},   exp_fs);
        tick();
        check("post_done", {31'd0, done_a}, 32'd0);
    endtask

    initial begin
        // Reset, then idle with start low.
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        check_idle("rst");
        for (int i = 0; i < 10; i++) begin
            tick();
            check_idle("idle");
        end

        // Basic frame: 101,1 -> PAR=1.
        run_frame(3'b101, 1'b1, 7'b0101111, -1);
        // Zero frame and the two parity cases.
        run_frame(3'b000, 1'b0, 7'b0000001, -1);
        run_frame(3'b110, 1'b0, 7'b0110001, -1);
        run_frame(3'b100, 1'b0, 7'b0100011, -1);

        // Isolation: upc change plus a start pulse at cycle 6 leave the frame intact.
        run_frame(3'b011, 1'b0, 7'b0011001, 6);
        for (int i = 0; i < 12; i++) begin
            tick();
            check_idle("no_second");
        end

        // Reset and start on the same edge: reset wins.
        reset = 1'b1; start_a = 1'b1;
        tick();
        reset = 1'b0; start_a = 1'b0;
        exp_fs = 0;
        check_idle("rst_start");

        // Reset mid-frame: the frame is abandoned and is not counted.
        upc = 3'b101; mark = 1'b1; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int k = 0; k < 13; k++) tick();
        check("mid_busy", {31'd0, busy_a}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("mid_rst");
        tick();
        run_frame(3'b101, 1'b1, 7'b0101111, -1);

        // Streaming: start held high. dut_b has a 29-cycle period, dut_c an 8-cycle period.
        upc = 3'b101; mark = 1'b1; start_s = 1'b1;
        tick();
        for (int k = 0; k < 5 * 29; k++) begin
            logic [6:0] bits;
            int pb, pc;
            bits = 7'b0101111;
            pb = k % 29;
            pc = k % 8;
            check("strm_b_busy", {31'd0, busy_b}, (pb != 28) ? 32'd1 : 32'd0);
            check("strm_b_done", {31'd0, done_b}, (pb == 28) ? 32'd1 : 32'd0);
            check("strm_b_tx",   {31'd0, tx_b},   (pb == 28) ? 32'd1 : {31'd0, bits[6 - pb/4]});
            check("strm_b_fs",   {30'd0, fs_b},   ((k + 1) / 29) % 4);
            check("strm_c_busy", {31'd0, busy_c}, (pc != 7) ? 32'd1 : 32'd0);
            check("strm_c_tx",   {31'd0, tx_c},   (pc == 7) ? 32'd1 : {31'd0, bits[6 - pc]});
            check("strm_c_fs",   {30'd0, fs_c},   ((k + 1) / 8) % 4);
            tick();
        end
        start_s = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
